cricket_match_ctrl: RTL and testbench

Parametrised match engine that replaces the fixed T20 scoring, ball-counting and comparison logic. It consumes one debounced delivery event with a random outcome code and runs both innings automatically: legal-ball and over counting, wides and no-balls, free hits, target chase and the result. It sits between the LFSR/debounce front end and the seven-segment and LED display drivers.

---
 rtl/cricket_pkg.sv | 33 +++
 rtl/cricket_match_ctrl_innings_tracker.sv | 114 +++++++++++
 rtl/cricket_match_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_cricket_match_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cricket_pkg.sv
// Shared constants and types for the cricket match engine.
// Super-over states are present only when CRICKET_SUPER_OVER_EN is defined.
package cricket_pkg;

   localparam logic [3:0] OC_RUN4    = 4'd4;
   localparam logic [3:0] OC_SIX     = 4'd5;
   localparam logic [3:0] OC_WIDE    = 4'd6;
   localparam logic [3:0] OC_NO_BALL = 4'd7;
   localparam logic [3:0] OC_WICKET  = 4'd8;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_TEAM1 = 2'b01;
   localparam logic [1:0] WIN_TEAM2 = 2'b10;
   localparam logic [1:0] WIN_TIE   = 2'b11;

   localparam logic [3:0] SO_WKTS = 4'd2;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_INN1      = 4'd1,
      ST_BREAK     = 4'd2,
      ST_INN2      = 4'd3,
      ST_DONE      = 4'd4
`ifdef CRICKET_SUPER_OVER_EN
      ,
      ST_SO_BREAK  = 4'd5,
      ST_SO1       = 4'd6,
      ST_SO_BREAK2 = 4'd7,
      ST_SO2       = 4'd8
`endif
   } match_state_e;

endpackage

// File: rtl/cricket_match_ctrl_innings_tracker.sv
// Per-innings scoreboard: runs, wickets, ball/over counters and free-hit flag.
// Exposes next-delivery values so the top can detect the innings end in the same update.
module innings_tracker
   import cricket_pkg::*;
#(
   parameter int BALLS_PER_OVER = 6,
   parameter int RUN_W          = 9,
   parameter int EXTRA_RUNS     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             deliver,
   input  logic [3:0]       outcome,
   output logic [RUN_W-1:0] runs,
   output logic [3:0]       wickets,
   output logic [5:0]       over_cnt,
   output logic [2:0]       ball_in_over,
   output logic             free_hit,
   output logic [RUN_W-1:0] runs_nxt,
   output logic [3:0]       wickets_nxt,
   output logic [5:0]       over_nxt
);

   logic [RUN_W-1:0] runs_r;
   logic [3:0]       wickets_r;
   logic [5:0]       over_r;
   logic [2:0]       ball_r;
   logic             free_hit_r;
   logic [2:0]       ball_nxt_s;
   logic             free_hit_nxt_s;
   logic             legal_s;
   logic [RUN_W:0]   run_add_s;
   logic [RUN_W:0]   run_sum_s;

   // Score the presented outcome against the current counters.
   always_comb begin
      legal_s   = (outcome != OC_WIDE) && (outcome != OC_NO_BALL);
      run_add_s = '0;
      if ((outcome >= 4'd1) && (outcome <= OC_RUN4)) begin
         run_add_s = (RUN_W+1)'(outcome);
      end else if (outcome == OC_SIX) begin
         run_add_s = (RUN_W+1)'(4'd6);
      end else if (!legal_s) begin
         run_add_s = (RUN_W+1)'(EXTRA_RUNS);
      end else begin
         run_add_s = '0;
      end
      run_sum_s = {1'b0, runs_r} + run_add_s;
      runs_nxt  = run_sum_s[RUN_W] ? '1 : run_sum_s[RUN_W-1:0];

      if ((outcome == OC_WICKET) && !free_hit_r) begin
         wickets_nxt = wickets_r + 4'd1;
      end else begin
         wickets_nxt = wickets_r;
      end

      // Any legal delivery consumes a pending free hit; a wide leaves it pending.
      if (outcome == OC_NO_BALL) begin
         free_hit_nxt_s = 1'b1;
      end else if (legal_s) begin
         free_hit_nxt_s = 1'b0;
      end else begin
         free_hit_nxt_s = free_hit_r;
      end

      if (!legal_s) begin
         ball_nxt_s = ball_r;
         over_nxt   = over_r;
      end else if (ball_r == 3'(BALLS_PER_OVER - 1)) begin
         ball_nxt_s = 3'd0;
         over_nxt   = over_r + 6'd1;
      end else begin
         ball_nxt_s = ball_r + 3'd1;
         over_nxt   = over_r;
      end
   end

   // Counter registers; clear takes priority over a delivery.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         runs_r     <= '0;
         wickets_r  <= 4'd0;
         over_r     <= 6'd0;
         ball_r     <= 3'd0;
         free_hit_r <= 1'b0;
      end else if (clear) begin
         runs_r     <= '0;
         wickets_r  <= 4'd0;
         over_r     <= 6'd0;
         ball_r     <= 3'd0;
         free_hit_r <= 1'b0;
      end else if (deliver) begin
         runs_r     <= runs_nxt;
         wickets_r  <= wickets_nxt;
         over_r     <= over_nxt;
         ball_r     <= ball_nxt_s;
         free_hit_r <= free_hit_nxt_s;
      end else begin
         runs_r     <= runs_r;
         wickets_r  <= wickets_r;
         over_r     <= over_r;
         ball_r     <= ball_r;
         free_hit_r <= free_hit_r;
      end
   end

   assign runs         = runs_r;
   assign wickets      = wickets_r;
   assign over_cnt     = over_r;
   assign ball_in_over = ball_r;
   assign free_hit     = free_hit_r;

endmodule

// File: rtl/cricket_match_ctrl.sv
// Two-innings cricket match engine: match FSM, target and result around one innings_tracker.
// Define CRICKET_SUPER_OVER_EN to resolve an innings-2 tie with a super over per side.
module cricket_match_ctrl
   import cricket_pkg::*;
#(
   parameter int OVERS          = 20,
   parameter int BALLS_PER_OVER = 6,
   parameter int MAX_WKTS       = 10,
   parameter int RUN_W          = 9,
   parameter int EXTRA_RUNS     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             ball_valid,
   input  logic [3:0]       outcome,
   output logic [RUN_W-1:0] runs,
   output logic [3:0]       wickets,
   output logic [5:0]       over_cnt,
   output logic [2:0]       ball_in_over,
   output logic [RUN_W-1:0] target,
   output logic [1:0]       inning,
   output logic             free_hit,
   output logic             inning_over,
   output logic             game_over,
   output logic [1:0]       winner
);

   match_state_e     state_r, state_nxt_s;
   logic [RUN_W-1:0] target_r, target_nxt_s;
   logic [1:0]       winner_r, winner_nxt_s, inning_r, inning_nxt_s;
   logic             game_over_r, game_over_nxt_s, inning_over_r, inning_over_nxt_s;
   logic             clear_s, deliver_s, in_play_s, super_s;
   logic             exhausted_s, chased_s, tie_s;
   logic [RUN_W-1:0] runs_nxt_s;
   logic [3:0]       wkts_nxt_s;
   logic [5:0]       over_nxt_s;
   logic [RUN_W:0]   target_sum_s;

   innings_tracker #(
      .BALLS_PER_OVER (BALLS_PER_OVER),
      .RUN_W          (RUN_W),
      .EXTRA_RUNS     (EXTRA_RUNS)
   ) u_tracker (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear_s),
      .deliver      (deliver_s),
      .outcome      (outcome),
      .runs         (runs),
      .wickets      (wickets),
      .over_cnt     (over_cnt),
      .ball_in_over (ball_in_over),
      .free_hit     (free_hit),
      .runs_nxt     (runs_nxt_s),
      .wickets_nxt  (wkts_nxt_s),
      .over_nxt     (over_nxt_s)
   );

   // Classify the delivery against the limits of the innings in play.
   always_comb begin
      in_play_s = (state_r == ST_INN1) || (state_r == ST_INN2);
      super_s   = 1'b0;
`ifdef CRICKET_SUPER_OVER_EN
      in_play_s = in_play_s || (state_r == ST_SO1) || (state_r == ST_SO2);
      super_s   = (state_r == ST_SO1) || (state_r == ST_SO2);
`endif
      deliver_s    = ball_valid && in_play_s;
      exhausted_s  = super_s ? ((over_nxt_s == 6'd1) || (wkts_nxt_s == SO_WKTS))
                             : ((over_nxt_s == 6'(OVERS)) || (wkts_nxt_s == 4'(MAX_WKTS)));
      target_sum_s = {1'b0, runs_nxt_s} + (RUN_W+1)'(1'b1);
      chased_s     = (runs_nxt_s >= target_r);
      tie_s        = (target_sum_s == {1'b0, target_r});
   end

   // Match FSM: next state, tracker clear, target latch and result.
   always_comb begin
      state_nxt_s       = state_r;
      target_nxt_s      = target_r;
      winner_nxt_s      = winner_r;
      game_over_nxt_s   = game_over_r;
      inning_nxt_s      = inning_r;
      inning_over_nxt_s = 1'b0;
      clear_s           = 1'b0;
      case (state_r)
         ST_IDLE, ST_BREAK: begin
            if (start) begin
               state_nxt_s  = (state_r == ST_IDLE) ? ST_INN1 : ST_INN2;
               inning_nxt_s = (state_r == ST_IDLE) ? 2'd1 : 2'd2;
               clear_s      = 1'b1;
            end else begin
               state_nxt_s  = state_r;
            end
         end
         ST_INN1: begin
            if (deliver_s && exhausted_s) begin
               state_nxt_s       = ST_BREAK;
               target_nxt_s      = target_sum_s[RUN_W] ? '1 : target_sum_s[RUN_W-1:0];
               clear_s           = 1'b1;
               inning_over_nxt_s = 1'b1;
            end else begin
               state_nxt_s       = ST_INN1;
            end
         end
         ST_INN2: begin
            if (deliver_s && (chased_s || exhausted_s)) begin
               inning_over_nxt_s = 1'b1;
               state_nxt_s       = ST_DONE;
               game_over_nxt_s   = 1'b1;
               if (chased_s) begin
                  winner_nxt_s = WIN_TEAM2;
               end else if (tie_s) begin
`ifdef CRICKET_SUPER_OVER_EN
                  state_nxt_s     = ST_SO_BREAK;
                  game_over_nxt_s = 1'b0;
`else
                  winner_nxt_s    = WIN_TIE;
`endif
               end else begin
                  winner_nxt_s = WIN_TEAM1;
               end
            end else begin
               state_nxt_s = ST_INN2;
            end
         end
`ifdef CRICKET_SUPER_OVER_EN
         ST_SO_BREAK, ST_SO_BREAK2: begin
            if (start) begin
               state_nxt_s  = (state_r == ST_SO_BREAK) ? ST_SO1 : ST_SO2;
               inning_nxt_s = 2'd3;
               clear_s      = 1'b1;
            end else begin
               state_nxt_s  = state_r;
            end
         end
         ST_SO1: begin
            if (deliver_s && exhausted_s) begin
               state_nxt_s       = ST_SO_BREAK2;
               target_nxt_s      = target_sum_s[RUN_W] ? '1 : target_sum_s[RUN_W-1:0];
               clear_s           = 1'b1;
               inning_over_nxt_s = 1'b1;
            end else begin
               state_nxt_s       = ST_SO1;
            end
         end
         ST_SO2: begin
            if (deliver_s && (chased_s || exhausted_s)) begin
               inning_over_nxt_s = 1'b1;
               state_nxt_s       = ST_DONE;
               game_over_nxt_s   = 1'b1;
               if (chased_s) begin
                  winner_nxt_s = WIN_TEAM2;
               end else if (tie_s) begin
                  winner_nxt_s = WIN_TIE;
               end else begin
                  winner_nxt_s = WIN_TEAM1;
               end
            end else begin
               state_nxt_s = ST_SO2;
            end
         end
`endif
         ST_DONE: begin
            state_nxt_s = ST_DONE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Match state and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         target_r      <= '0;
         winner_r      <= WIN_NONE;
         game_over_r   <= 1'b0;
         inning_r      <= 2'd0;
         inning_over_r <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         target_r      <= target_nxt_s;
         winner_r      <= winner_nxt_s;
         game_over_r   <= game_over_nxt_s;
         inning_r      <= inning_nxt_s;
         inning_over_r <= inning_over_nxt_s;
      end
   end

   assign target      = target_r;
   assign winner      = winner_r;
   assign game_over   = game_over_r;
   assign inning      = inning_r;
   assign inning_over = inning_over_r;

endmodule

// File: tb/tb_cricket_match_ctrl.sv
// Self-checking bench for cricket_match_ctrl (OVERS=2, 6 balls/over) with directed
// scenarios and randomized matches checked against a rule-level match model.
module tb_cricket_match_ctrl;

   localparam int OV = 2, BPO = 6, MW = 10, RW = 9, EX = 1;
   localparam int SAT = (1 << RW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          ball_valid = 1'b0;
   logic [3:0]    outcome = 4'd0;
   logic [RW-1:0] runs, target;
   logic [3:0]    wickets;
   logic [5:0]    over_cnt;
   logic [2:0]    ball_in_over;
   logic [1:0]    inning, winner;
   logic          free_hit, inning_over, game_over;

   int errors = 0;
   int checks = 0;

   cricket_match_ctrl #(.OVERS(OV), .BALLS_PER_OVER(BPO), .MAX_WKTS(MW), .RUN_W(RW), .EXTRA_RUNS(EX)) dut (
      .clk(clk), .rst(rst), .start(start), .ball_valid(ball_valid), .outcome(outcome),
      .runs(runs), .wickets(wickets), .over_cnt(over_cnt), .ball_in_over(ball_in_over),
      .target(target), .inning(inning), .free_hit(free_hit), .inning_over(inning_over),
      .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;

   wire [37:0] act_vec = {runs, wickets, over_cnt, ball_in_over, target, inning,
                          free_hit, inning_over, game_over, winner};

   // Match model. Phases: 0 idle, 1 inn1, 2 break, 3 inn2, 4 done,
   // 5 super-over break, 6 super over 1, 7 super-over break 2, 8 super over 2.
   int m_ph, m_runs, m_wk, m_legal, m_tgt, m_inn, m_win;
   bit m_fh, m_io, m_go;

   task automatic model_reset();
      m_ph = 0; m_runs = 0; m_wk = 0; m_legal = 0; m_tgt = 0; m_inn = 0; m_win = 0;
      m_fh = 0; m_io = 0; m_go = 0;
   endtask

   task automatic model(input bit st, input bit bv, input int oc);
      int add;
      bit legal, ends, sup;
      m_io = 0;
      if (st && (m_ph == 0 || m_ph == 2 || m_ph == 5 || m_ph == 7)) begin
         m_ph = m_ph + 1;
         m_runs = 0; m_wk = 0; m_legal = 0; m_fh = 0;
         m_inn = (m_ph == 1) ? 1 : (m_ph == 3) ? 2 : 3;
      end else if (bv && (m_ph == 1 || m_ph == 3 || m_ph == 6 || m_ph == 8)) begin
         sup   = (m_ph >= 6);
         legal = !(oc == 6 || oc == 7);
         add   = (oc >= 1 && oc <= 4) ? oc : (oc == 5) ? 6 : (!legal) ? EX : 0;
         m_runs = (m_runs + add > SAT) ? SAT : m_runs + add;
         if (oc == 8 && !m_fh) m_wk++;
         if (oc == 7) m_fh = 1;
         else if (legal) m_fh = 0;
         if (legal) m_legal++;
         ends = (m_legal / BPO == (sup ? 1 : OV)) || (m_wk == (sup ? 2 : MW));
         if ((m_ph == 3 || m_ph == 8) && m_runs >= m_tgt) begin
            m_io = 1; m_go = 1; m_win = 2; m_ph = 4;
         end else if (ends) begin
            m_io = 1;
            if (m_ph == 1 || m_ph == 6) begin
               m_tgt = (m_runs + 1 > SAT) ? SAT : m_runs + 1;
               m_runs = 0; m_wk = 0; m_legal = 0; m_fh = 0;
               m_ph = m_ph + 1;
            end else if (m_runs == m_tgt - 1) begin
`ifdef CRICKET_SUPER_OVER_EN
               if (m_ph == 3) m_ph = 5;
               else begin m_ph = 4; m_go = 1; m_win = 3; end
`else
               m_ph = 4; m_go = 1; m_win = 3;
`endif
            end else begin
               m_ph = 4; m_go = 1; m_win = 1;
            end
         end
      end
   endtask

   function automatic logic [37:0] exp_vec();
      return {RW'(m_runs), 4'(m_wk), 6'(m_legal / BPO), 3'(m_legal % BPO), RW'(m_tgt),
              2'(m_inn), m_fh, m_io, m_go, 2'(m_win)};
   endfunction

   task automatic drive(input bit st, input bit bv, input logic [3:0] oc);
      start = st; ball_valid = bv; outcome = oc;
      model(st, bv, int'(oc));
      @(posedge clk); #1;
      start = 1'b0; ball_valid = 1'b0; outcome = 4'd0;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; ball_valid = 1'b0;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (act_vec !== 38'd0) begin
         errors++; $display("FAIL reset_state: got %h expected 0", act_vec);
      end
      rst = 1'b0;
      model_reset();
      drive(1'b0, 1'b1, 4'd4);
      checks++;
      if ({runs, inning} !== {9'd0, 2'd0}) begin
         errors++; $display("FAIL ball_before_start: runs=%0d inning=%0d expected 0 0", runs, inning);
      end
   endtask

   task automatic test_basic_chase();
      do_reset();
      drive(1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 11; i++) drive(1'b0, 1'b1, 4'd1);
      checks++;
      if ({runs, inning_over, over_cnt, ball_in_over} !== {9'd11, 1'b0, 6'd1, 3'd5}) begin
         errors++; $display("FAIL inn1_progress: runs=%0d io=%0d ov=%0d b=%0d expected 11 0 1 5",
                            runs, inning_over, over_cnt, ball_in_over);
      end
      drive(1'b0, 1'b1, 4'd1);
      checks++;
      if ({inning_over, target, runs, inning} !== {1'b1, 9'd13, 9'd0, 2'd1}) begin
         errors++; $display("FAIL inn1_end: io=%0d target=%0d runs=%0d inning=%0d expected 1 13 0 1",
                            inning_over, target, runs, inning);
      end
      drive(1'b0, 1'b0, 4'd0);
      checks++;
      if (inning_over !== 1'b0) begin
         errors++; $display("FAIL inning_over_pulse: got %0d expected 0", inning_over);
      end
      drive(1'b1, 1'b0, 4'd0);
      drive(1'b0, 1'b1, 4'd5);
      drive(1'b0, 1'b1, 4'd5);
      checks++;
      if ({runs, game_over, winner} !== {9'd12, 1'b0, 2'b00}) begin
         errors++; $display("FAIL chase_pending: runs=%0d go=%0d win=%0d expected 12 0 0", runs, game_over, winner);
      end
      drive(1'b0, 1'b1, 4'd1);
      checks++;
      if ({runs, game_over, winner, inning_over} !== {9'd13, 1'b1, 2'b10, 1'b1}) begin
         errors++; $display("FAIL chase_win: runs=%0d go=%0d win=%0d io=%0d expected 13 1 2 1",
                            runs, game_over, winner, inning_over);
      end
      drive(1'b1, 1'b1, 4'd4);
      checks++;
      if ({runs, game_over, winner, inning} !== {9'd13, 1'b1, 2'b10, 2'd2}) begin
         errors++; $display("FAIL done_hold: runs=%0d go=%0d win=%0d inning=%0d expected 13 1 2 2",
                            runs, game_over, winner, inning);
      end
   endtask

   task automatic test_wickets();
      do_reset();
      drive(1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 4'd8);
      checks++;
      if ({wickets, over_cnt, ball_in_over, inning_over} !== {4'd9, 6'd1, 3'd3, 1'b0}) begin
         errors++; $display("FAIL nine_wickets: wk=%0d ov=%0d b=%0d io=%0d expected 9 1 3 0",
                            wickets, over_cnt, ball_in_over, inning_over);
      end
      drive(1'b0, 1'b1, 4'd8);
      checks++;
      if ({inning_over, target, wickets, over_cnt, ball_in_over} !== {1'b1, 9'd1, 4'd0, 6'd0, 3'd0}) begin
         errors++; $display("FAIL all_out: io=%0d target=%0d wk=%0d ov=%0d b=%0d expected 1 1 0 0 0",
                            inning_over, target, wickets, over_cnt, ball_in_over);
      end
   endtask

   task automatic test_free_hit();
      do_reset();
      drive(1'b1, 1'b0, 4'd0);
      drive(1'b0, 1'b1, 4'd7);
      checks++;
      if ({runs, free_hit, ball_in_over} !== {9'd1, 1'b1, 3'd0}) begin
         errors++; $display("FAIL no_ball: runs=%0d fh=%0d b=%0d expected 1 1 0", runs, free_hit, ball_in_over);
      end
      drive(1'b0, 1'b1, 4'd8);
      checks++;
      if ({wickets, free_hit, ball_in_over, runs} !== {4'd0, 1'b0, 3'd1, 9'd1}) begin
         errors++; $display("FAIL free_hit_wicket: wk=%0d fh=%0d b=%0d runs=%0d expected 0 0 1 1",
                            wickets, free_hit, ball_in_over, runs);
      end
      drive(1'b0, 1'b1, 4'd8);
      checks++;
      if ({wickets, free_hit, ball_in_over} !== {4'd1, 1'b0, 3'd2}) begin
         errors++; $display("FAIL normal_wicket: wk=%0d fh=%0d b=%0d expected 1 0 2", wickets, free_hit, ball_in_over);
      end
      drive(1'b0, 1'b1, 4'd6);
      checks++;
      if ({runs, ball_in_over} !== {9'd2, 3'd2}) begin
         errors++; $display("FAIL wide: runs=%0d b=%0d expected 2 2", runs, ball_in_over);
      end
      drive(1'b0, 1'b1, 4'd7);
      drive(1'b0, 1'b1, 4'd6);
      checks++;
      if ({runs, free_hit} !== {9'd4, 1'b1}) begin
         errors++; $display("FAIL wide_keeps_free_hit: runs=%0d fh=%0d expected 4 1", runs, free_hit);
      end
   endtask

   task automatic test_tie();
      do_reset();
      drive(1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, (i < 6) ? 4'd1 : 4'd0);
      drive(1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 11; i++) drive(1'b0, 1'b1, (i < 5) ? 4'd1 : 4'd0);
      checks++;
      if ({runs, target, game_over} !== {9'd5, 9'd7, 1'b0}) begin
         errors++; $display("FAIL tie_pending: runs=%0d target=%0d go=%0d expected 5 7 0", runs, target, game_over);
      end
      drive(1'b0, 1'b1, 4'd1);
      checks++;
`ifdef CRICKET_SUPER_OVER_EN
      if ({runs, inning_over, game_over, winner} !== {9'd6, 1'b1, 1'b0, 2'b00}) begin
         errors++; $display("FAIL tie_super_over: runs=%0d io=%0d go=%0d win=%0d expected 6 1 0 0",
                            runs, inning_over, game_over, winner);
      end
`else
      if ({runs, inning_over, game_over, winner} !== {9'd6, 1'b1, 1'b1, 2'b11}) begin
         errors++; $display("FAIL tie_result: runs=%0d io=%0d go=%0d win=%0d expected 6 1 1 3",
                            runs, inning_over, game_over, winner);
      end
`endif
   endtask

   task automatic test_saturation();
      do_reset();
      drive(1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 515; i++) drive(1'b0, 1'b1, 4'd6);
      drive(1'b0, 1'b1, 4'd5);
      checks++;
      if ({runs, ball_in_over} !== {9'd511, 3'd1}) begin
         errors++; $display("FAIL runs_saturate: runs=%0d b=%0d expected 511 1", runs, ball_in_over);
      end
      for (int i = 0; i < 11; i++) drive(1'b0, 1'b1, 4'd0);
      checks++;
      if ({inning_over, target} !== {1'b1, 9'd511}) begin
         errors++; $display("FAIL target_saturate: io=%0d target=%0d expected 1 511", inning_over, target);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 4'd5);
      drive(1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 4'd4);
      checks++;
      if ({runs, target, inning} !== {9'd40, 9'd73, 2'd2}) begin
         errors++; $display("FAIL mid_inn2: runs=%0d target=%0d inning=%0d expected 40 73 2", runs, target, inning);
      end
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (act_vec !== 38'd0) begin
         errors++; $display("FAIL async_reset: got %h expected 0", act_vec);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b0, 1'b1, 4'd4);
      checks++;
      if (act_vec !== 38'd0) begin
         errors++; $display("FAIL idle_after_reset: got %h expected 0", act_vec);
      end
   endtask

   task automatic test_start_with_ball();
      do_reset();
      drive(1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 4'd8);
      drive(1'b1, 1'b1, 4'd4);
      checks++;
      if ({inning, runs, ball_in_over, target} !== {2'd2, 9'd0, 3'd0, 9'd1}) begin
         errors++; $display("FAIL start_wins: inning=%0d runs=%0d b=%0d target=%0d expected 2 0 0 1",
                            inning, runs, ball_in_over, target);
      end
   endtask

   task automatic test_random();
      int r;
      bit st, bv;
      for (int g = 0; g < 8; g++) begin
         do_reset();
         for (int c = 0; c < 300 && !m_go; c++) begin
            r  = int'($urandom_range(0, 9));
            st = (m_ph == 0 || m_ph == 2 || m_ph == 5 || m_ph == 7) ? (r < 3) : (r == 9);
            bv = (r < 8);
            drive(st, bv, 4'($urandom_range(0, 15)));
            checks++;
            if (act_vec !== exp_vec()) begin
               errors++; $display("FAIL random_g%0d_c%0d: got %h expected %h", g, c, act_vec, exp_vec());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_chase();
      test_wickets();
      test_free_hit();
      test_tie();
      test_saturation();
      test_reset_mid();
      test_start_with_ball();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
